// File: rtl/sr_cmd_ctrl.sv
// sr_cmd_ctrl: upstream command stage for a D-based SR flip-flop.
// Turns handshaked SET/CLEAR/TOGGLE/NOP commands into single-cycle S/R
// pulses, then verifies the flip-flop's Q feedback. A failed check is
// retried up to MAX_RETRY times, after which the sticky FAIL state is held
// until err_clr is seen.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous active-low reset
//   cmd_valid  command present (accepted when cmd_ready=1)
//   cmd        00 NOP, 01 SET, 10 CLEAR, 11 TOGGLE
//   q_fb       Q of the downstream SR flip-flop
//   err_clr    leaves FAIL (ignored in other states)
//   cmd_ready  controller idle and able to accept a command
//   S, R       set / reset drive, never both high
//   done       one-cycle pulse: command complete with Q verified
//   fail       sticky: retries exhausted
module sr_cmd_ctrl #(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic       q_fb,
  input  logic       err_clr,
  output logic       cmd_ready,
  output logic       S,
  output logic       R,
  output logic       done,
  output logic       fail
);

  localparam int unsigned CMD_W   = 2;
  localparam int unsigned RETRY_W = 3;

  localparam logic [CMD_W-1:0] CMD_NOP   = 2'b00;
  localparam logic [CMD_W-1:0] CMD_SET   = 2'b01;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_FAIL
  } state_e;

  state_e               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 target_q, target_d;
  logic                 ready_q, ready_d;
  logic                 s_q, s_d;
  logic                 r_q, r_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 accept;

  // Next state, retry/target bookkeeping and next registered outputs.
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    target_d = target_q;
    done_d   = 1'b0;
    accept   = cmd_valid && ready_q && (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd == CMD_NOP) begin
            done_d = 1'b1;
          end else begin
            if (cmd == CMD_SET) begin
              target_d = 1'b1;
            end else if (cmd == CMD_CLEAR) begin
              target_d = 1'b0;
            end else begin
              target_d = ~q_fb;
            end
            retry_d = '0;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (q_fb == target_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        if (err_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered, so each is a clean register.
    s_d     = (state_d == ST_DRIVE) &&  target_d;
    r_d     = (state_d == ST_DRIVE) && !target_d;
    ready_d = (state_d == ST_IDLE);
    fail_d  = (state_d == ST_FAIL);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      target_q <= 1'b0;
      ready_q  <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      target_q <= target_d;
      ready_q  <= ready_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign cmd_ready = ready_q;
  assign S         = s_q;
  assign R         = r_q;
  assign done      = done_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_sr_cmd_ctrl.sv
// tb_sr_cmd_ctrl: directed, table-driven bench for sr_cmd_ctrl with a
// behavioural SR flip-flop closing the q_fb loop (optionally overridden to
// model a stuck flip-flop).
module tb_sr_cmd_ctrl;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd       = 2'b00;
  logic       err_clr   = 1'b0;
  logic       q_fb;
  logic       cmd_ready, S, R, done, fail;

  logic       ff_q;
  logic       ovr_en  = 1'b0;
  logic       ovr_val = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [4:0] outs;
  assign outs = {cmd_ready, S, R, done, fail};

  sr_cmd_ctrl #(.MAX_RETRY(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .q_fb      (q_fb),
    .err_clr   (err_clr),
    .cmd_ready (cmd_ready),
    .S         (S),
    .R         (R),
    .done      (done),
    .fail      (fail)
  );

  always #5 clock = ~clock;

  // Downstream SR flip-flop model.
  always @(posedge clock or negedge reset) begin
    if (!reset)  ff_q <= 1'b0;
    else if (S)  ff_q <= 1'b1;
    else if (R)  ff_q <= 1'b0;
  end
  assign q_fb = ovr_en ? ovr_val : ff_q;

  // S and R must never be high together.
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (S && R) begin
        failures++;
        $display("FAIL sr_exclusive at %0t: S=%0b R=%0b required not both 1", $time, S, R);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] c;
    logic       ec;
    logic [4:0] exp;   // {cmd_ready, S, R, done, fail} after the edge
  } vec_t;

  vec_t vecs[16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] stream[4];
    int pulses, idx, s_cnt, r_cnt, d_cnt;
    logic acc;

    vecs[0]  = '{1'b0, 2'b00, 1'b0, 5'b10000}; // first edge after reset
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 5'b01000}; // SET accepted, S pulse
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 5'b00000}; // CHECK
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 5'b10010}; // match -> done
    vecs[4]  = '{1'b1, 2'b11, 1'b0, 5'b00100}; // TOGGLE with q=1 -> R
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 5'b00000};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 5'b10010};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 5'b10010}; // NOP: done next cycle
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 5'b10000};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 5'b00100}; // CLEAR -> R
    vecs[10] = '{1'b0, 2'b00, 1'b0, 5'b00000};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 5'b10010};
    vecs[12] = '{1'b1, 2'b01, 1'b0, 5'b01000}; // SET
    vecs[13] = '{1'b1, 2'b10, 1'b0, 5'b00000}; // ignored in DRIVE
    vecs[14] = '{1'b1, 2'b10, 1'b0, 5'b10010}; // ignored in CHECK
    vecs[15] = '{1'b0, 2'b00, 1'b1, 5'b10000}; // err_clr ignored in IDLE

    // Asynchronous reset.
    #1 reset = 1'b0;
    #2 check("reset_async", 32'(outs), 32'h0);
    step();
    check("reset_held", 32'(outs), 32'h0);
    #3 reset = 1'b1;

    // Table-driven main function.
    for (int i = 0; i < 16; i++) begin
      cmd_valid = vecs[i].vld;
      cmd       = vecs[i].c;
      err_clr   = vecs[i].ec;
      step();
      check($sformatf("vec[%0d]", i), 32'(outs), 32'(vecs[i].exp));
    end
    cmd_valid = 1'b0;
    err_clr   = 1'b0;

    // Stuck flip-flop: 4 S pulses two cycles apart, then FAIL.
    ovr_en  = 1'b1;
    ovr_val = 1'b0;
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    step();
    check("stuck_first_S", 32'(S), 32'h1);
    pulses = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (S) pulses++;
      check($sformatf("stuck_S[%0d]", k), 32'(S), 32'((k % 2 == 0) && (k <= 6)));
      check($sformatf("stuck_R_done[%0d]", k), 32'({R, done}), 32'h0);
      check($sformatf("stuck_fail[%0d]", k), 32'(fail), 32'(k >= 8));
    end
    check("stuck_pulses", 32'(pulses), 32'd4);
    check("stuck_ready", 32'(cmd_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("fail_hold[%0d]", k), 32'(outs), 32'b00001);
    end
    cmd_valid = 1'b0;
    err_clr   = 1'b1;
    step();
    check("err_clr", 32'(outs), 32'b10000);
    err_clr = 1'b0;
    ovr_en  = 1'b0;

    // Reset while S is high.
    cmd_valid = 1'b1;
    cmd       = 2'b01;
    step();
    check("mid_drive_S", 32'(S), 32'h1);
    cmd_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check("mid_drive_reset", 32'(outs), 32'h0);
    step();
    check("mid_drive_held", 32'(outs), 32'h0);
    #3 reset = 1'b1;
    step();
    check("mid_drive_release", 32'(outs), 32'b10000);
    step();
    check("mid_drive_no_done", 32'(outs), 32'b10000);

    // Streaming SET, CLEAR, TOGGLE, NOP with cmd_valid held.
    stream[0] = 2'b01;
    stream[1] = 2'b10;
    stream[2] = 2'b11;
    stream[3] = 2'b00;
    idx = 0; s_cnt = 0; r_cnt = 0; d_cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (idx < 4) begin
        cmd_valid = 1'b1;
        cmd       = stream[idx];
      end else begin
        cmd_valid = 1'b0;
      end
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) idx++;
      if (S) s_cnt++;
      if (R) r_cnt++;
      if (done) d_cnt++;
    end
    check("stream_accepts", 32'(idx), 32'd4);
    check("stream_done", 32'(d_cnt), 32'd4);
    check("stream_S", 32'(s_cnt), 32'd2);
    check("stream_R", 32'(r_cnt), 32'd1);
    check("stream_idle", 32'(outs), 32'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_cmd_ctrl.md
SR_CMD_CTRL -- requirements
Module: sr_cmd_ctrl

Upstream command stage for the SR flip-flop (D-based conversion). Converts handshaked set/clear/toggle commands into single-cycle S/R pulses, then checks the flip-flop's Q feedback.

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: extra drive attempts after the first before failure (range 0..7).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clock).
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd  input  2  00 NOP, 01 SET, 10 CLEAR, 11 TOGGLE.
REQ-006 SHALL have port q_fb  input  1  Q output of the downstream SR flip-flop.
REQ-007 SHALL have port err_clr  input  1  clears the FAIL state.
REQ-008 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-009 SHALL have port S  output  1  set drive to the flip-flop.
REQ-010 SHALL have port R  output  1  reset drive to the flip-flop.
REQ-011 SHALL have port done  output  1  one-cycle pulse: command completed with Q verified.
REQ-012 SHALL have port fail  output  1  sticky: retries exhausted.

Function
REQ-013 SHALL register all outputs; no combinational input-to-output path.
REQ-014 SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 only in IDLE.
REQ-015 SHALL implement states IDLE, DRIVE, CHECK, FAIL.
REQ-016 SHALL, on SET/CLEAR/TOGGLE acceptance, latch the target (SET->1, CLEAR->0, TOGGLE->~q_fb sampled at acceptance edge), zero the retry count and go to DRIVE.
REQ-017 SHALL, in DRIVE, hold exactly one of S/R high for exactly one clock (S if target=1, R if target=0), then go to CHECK.
REQ-018 SHALL never drive S=1 and R=1 in the same cycle, under any input sequence or reset.
REQ-019 SHALL, in CHECK, compare q_fb with target at the next edge: match -> IDLE with done=1 for one cycle; mismatch and retry count < MAX_RETRY -> increment count, back to DRIVE; mismatch and count = MAX_RETRY -> FAIL.
REQ-020 SHALL give done=1 in the cycle after the second rising edge following acceptance when the first attempt matches; each retry adds 2 cycles.
REQ-021 SHALL treat NOP as accepted with no S/R activity and done=1 in the cycle after the acceptance edge.
REQ-022 SHALL, in FAIL, hold fail=1, S=R=0 and cmd_ready=0 until err_clr=1 at an edge, then return to IDLE with fail=0.
REQ-023 SHALL ignore cmd_valid and cmd outside IDLE. Commands are not queued.
REQ-024 SHALL permit back-to-back commands: a new command is accepted at the edge after done's rising edge, when cmd_ready is 1 again.
REQ-025 SHALL ignore err_clr outside FAIL.

Reset
REQ-026 SHALL, while reset=0, force state=IDLE, S=0, R=0, done=0, fail=0, cmd_ready=0, retry count=0 and target=0, asynchronously.
REQ-027 SHALL set cmd_ready=1 on the first rising edge after reset returns to 1.
REQ-028 SHALL abort any in-flight command on reset with no done pulse; S/R SHALL drop to 0 immediately.

Verification
REQ-029 SHALL verify SET: reset pulse, cmd=01 accepted, q_fb follows S after one edge -> S=1 for 1 cycle, R=0 throughout, done=1 for 1 cycle two edges after acceptance, fail=0.
REQ-030 SHALL verify TOGGLE with q_fb=1: cmd=11 -> R=1 for 1 cycle, S=0, target 0, done after q_fb=0.
REQ-031 SHALL verify a stuck flip-flop: q_fb held 0, SET, MAX_RETRY=3 -> exactly 4 single-cycle S pulses 2 cycles apart, then fail=1, cmd_ready=0; err_clr=1 -> fail=0, cmd_ready=1.
REQ-032 SHALL verify reset mid-DRIVE: reset=0 while S=1 -> S=0 immediately, no done; after release cmd_ready=1 at the first edge.
REQ-033 SHALL verify streaming: cmd_valid held 1 with SET, CLEAR, TOGGLE, NOP back-to-back -> each completes with one done, S&R never both 1 (checked every cycle).
REQ-034 SHALL verify NOP: cmd=00 -> S=R=0, done=1 one cycle after acceptance.
